// File: rtl/rst_req_sched.sv
// rst_req_sched: reset-request scheduler in front of the cold/warm boot sequencer.
//
// Collects per-requester warm/cold reset requests (rising-edge detected) and the
// active-low watchdog timeout (falling-edge detected). Arbitrates them with the
// watchdog first, then the cold class, then the warm class, round-robin within a
// class. Each grant produces a one-cycle enable pulse, followed by a lockout of
// LOCKOUT_S ticks of TICK_DIV clocks each.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_warm/req_cold  per-requester requests (rising edge = request)
//   req_mask           1 = requester enabled, 0 = ignored and its pending bits dropped
//   wdg_timeout_n      watchdog timeout, falling edge = cold request
//   enable_cold_boot   one-cycle pulse (cold or watchdog grant)
//   enable_warm_boot   one-cycle pulse (warm grant)
//   grant_id           last granted requester, 7 = watchdog
//   busy               high while arbitrating, issuing or locked out
//   issue_cnt          saturating issued-pulse count (status option)
//   last_cause         00 none, 01 warm, 10 cold, 11 watchdog (status option)
//
// Option macro: RST_SCHED_STATUS_EN enables issue_cnt / last_cause; when it is
// undefined both ports are tied to zero.
module rst_req_sched #(
    parameter int NREQ      = 4,
    parameter int TICK_DIV  = 10,
    parameter int LOCKOUT_S = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_warm,
    input  logic [NREQ-1:0] req_cold,
    input  logic [NREQ-1:0] req_mask,
    input  logic            wdg_timeout_n,
    output logic            enable_cold_boot,
    output logic            enable_warm_boot,
    output logic [2:0]      grant_id,
    output logic            busy,
    output logic [7:0]      issue_cnt,
    output logic [1:0]      last_cause
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Class codes double as last_cause encodings.
    localparam logic [1:0] CLS_WARM = 2'b01;
    localparam logic [1:0] CLS_COLD = 2'b10;
    localparam logic [1:0] CLS_WDG  = 2'b11;

    typedef enum logic [1:0] {IDLE, ARB, ISSUE, LOCKOUT} state_t;
    state_t state, state_nxt;

    logic [NREQ-1:0] warm_prev, cold_prev, warm_pend, cold_pend;
    logic [NREQ-1:0] warm_set, cold_set, warm_clr, cold_clr;
    logic [NREQ-1:0] warm_eff, cold_eff, win_onehot;
    logic            wdg_prev, wdg_pend, wdg_set, wdg_clr;
    logic [2:0]      rr_warm, rr_cold, win_idx;
    logic [1:0]      win_cls, gcls;
    logic            win_vld, arb_fire, lock_done;
    logic [DW-1:0]   div;
    logic [7:0]      lcnt;

    // First set bit at or after ptr, wrapping at NREQ. Scanning downward lets the
    // lowest offset overwrite the result last.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] ptr);
        int j;
        rr_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (v[j]) rr_pick = 3'(j);
        end
    endfunction

    function automatic logic [2:0] ptr_after(input logic [2:0] i);
        ptr_after = (int'(i) == NREQ - 1) ? 3'd0 : i + 3'd1;
    endfunction

    // Cold wins a same-cycle warm/cold edge from the same requester.
    assign cold_set = req_cold & ~cold_prev & req_mask;
    assign warm_set = req_warm & ~warm_prev & req_mask & ~cold_set;
    assign wdg_set  = wdg_prev & ~wdg_timeout_n;

    // Winner selection uses the mask of the arbitration cycle, so a requester
    // masked off in that very cycle cannot be granted.
    always_comb begin
        cold_eff = cold_pend & req_mask;
        warm_eff = warm_pend & req_mask;
        win_vld  = 1'b1;
        win_cls  = CLS_WDG;
        win_idx  = 3'd7;
        if (wdg_pend) begin
            win_cls = CLS_WDG;
        end else if (|cold_eff) begin
            win_cls = CLS_COLD;
            win_idx = rr_pick(cold_eff, rr_cold);
        end else if (|warm_eff) begin
            win_cls = CLS_WARM;
            win_idx = rr_pick(warm_eff, rr_warm);
        end else begin
            win_vld = 1'b0;
            win_idx = 3'd0;
        end
    end

    assign arb_fire   = (state == ARB) && win_vld;
    assign win_onehot = NREQ'(1) << win_idx;
    assign cold_clr   = (arb_fire && win_cls == CLS_COLD) ? win_onehot : '0;
    assign warm_clr   = (arb_fire && win_cls == CLS_WARM) ? win_onehot : '0;
    assign wdg_clr    = arb_fire && (win_cls == CLS_WDG);
    assign lock_done  = (div == DW'(TICK_DIV - 1)) && (lcnt == 8'(LOCKOUT_S - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_prev <= '0;
            cold_prev <= '0;
            wdg_prev  <= 1'b1;
            warm_pend <= '0;
            cold_pend <= '0;
            wdg_pend  <= 1'b0;
        end else begin
            warm_prev <= req_warm;
            cold_prev <= req_cold;
            wdg_prev  <= wdg_timeout_n;
            // A new edge beats the grant clear; the mask drops everything.
            cold_pend <= ((cold_pend & ~cold_clr) | cold_set) & req_mask;
            warm_pend <= ((warm_pend & ~warm_clr) | warm_set) & req_mask;
            wdg_pend  <= (wdg_pend & ~wdg_clr) | wdg_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            gcls     <= CLS_WARM;
            rr_warm  <= '0;
            rr_cold  <= '0;
            div      <= '0;
            lcnt     <= '0;
        end else begin
            state <= state_nxt;
            if (arb_fire) begin
                grant_id <= win_idx;
                gcls     <= win_cls;
                if (win_cls == CLS_COLD) rr_cold <= ptr_after(win_idx);
                if (win_cls == CLS_WARM) rr_warm <= ptr_after(win_idx);
            end
            if (state == ISSUE) begin
                div  <= '0;
                lcnt <= '0;
            end else if (state == LOCKOUT) begin
                if (div == DW'(TICK_DIV - 1)) begin
                    div  <= '0;
                    lcnt <= lcnt + 8'd1;
                end else begin
                    div <= div + DW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        enable_cold_boot = 1'b0;
        enable_warm_boot = 1'b0;
        busy             = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|cold_pend || |warm_pend || wdg_pend) state_nxt = ARB;
            end
            ARB:     state_nxt = win_vld ? ISSUE : IDLE;
            ISSUE: begin
                enable_cold_boot = (gcls != CLS_WARM);
                enable_warm_boot = (gcls == CLS_WARM);
                state_nxt        = LOCKOUT;
            end
            LOCKOUT: if (lock_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RST_SCHED_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt  <= '0;
            last_cause <= '0;
        end else if (state == ISSUE) begin
            if (issue_cnt != 8'hFF) issue_cnt <= issue_cnt + 8'd1;
            last_cause <= gcls;
        end
    end
`else
    assign issue_cnt  = '0;
    assign last_cause = '0;
`endif

endmodule

// File: tb/tb_rst_req_sched.sv
// Bench for rst_req_sched: directed table, hand-written corner sequences and a
// random phase, all cross-checked every cycle against a timeline model.
module tb_rst_req_sched;
    localparam int N    = 4;
    localparam int LOCK = 5 * 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_warm = '0, req_cold = '0, req_mask = '1;
    logic         wdg_timeout_n = 1'b1;
    logic         enable_cold_boot, enable_warm_boot, busy;
    logic [2:0]   grant_id;
    logic [7:0]   issue_cnt;
    logic [1:0]   last_cause;

    int total = 0, bad = 0;
    bit chk_on = 1'b0;

    rst_req_sched #(.NREQ(N), .TICK_DIV(10), .LOCKOUT_S(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_warm(req_warm), .req_cold(req_cold),
        .req_mask(req_mask), .wdg_timeout_n(wdg_timeout_n),
        .enable_cold_boot(enable_cold_boot), .enable_warm_boot(enable_warm_boot),
        .grant_id(grant_id), .busy(busy), .issue_cnt(issue_cnt), .last_cause(last_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pos is the cycle's place in a grant window: 0 idle, 1 arbitrate,
    // 2 pulse, 3..LOCK+2 lockout.
    int     m_pos, m_gid, m_cls, m_rrw, m_rrc, m_cnt, m_cause;
    bit [N-1:0] m_wp, m_cp, m_wprev, m_cprev;
    bit     m_dp, m_dprev;

    function automatic int find_rr(input bit [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_pos = 0; m_gid = 0; m_cls = 0; m_rrw = 0; m_rrc = 0; m_cnt = 0; m_cause = 0;
        m_wp = '0; m_cp = '0; m_wprev = '0; m_cprev = '0; m_dp = 0; m_dprev = 1;
    endtask

    initial m_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else begin
            bit [N-1:0] cw, cc, sw, sc;
            bit cd, sd;
            int w;
            cw = '0; cc = '0; cd = 0;
            if (m_pos == 0) begin
                if (m_wp != 0 || m_cp != 0 || m_dp) m_pos = 1;
            end else if (m_pos == 1) begin
                m_pos = 2;
                if (m_dp) begin
                    m_gid = 7; m_cls = 3; cd = 1;
                end else if ((m_cp & req_mask) != 0) begin
                    w = find_rr(m_cp & req_mask, m_rrc);
                    m_gid = w; m_cls = 2; cc[w] = 1; m_rrc = (w + 1) % N;
                end else if ((m_wp & req_mask) != 0) begin
                    w = find_rr(m_wp & req_mask, m_rrw);
                    m_gid = w; m_cls = 1; cw[w] = 1; m_rrw = (w + 1) % N;
                end else m_pos = 0;
            end else if (m_pos == 2) begin
                if (m_cnt < 255) m_cnt++;
                m_cause = m_cls;
                m_pos = 3;
            end else m_pos = (m_pos == LOCK + 2) ? 0 : m_pos + 1;
            sc = req_cold & ~m_cprev & req_mask;
            sw = req_warm & ~m_wprev & req_mask & ~sc;
            sd = m_dprev & ~wdg_timeout_n;
            m_cp = ((m_cp & ~cc) | sc) & req_mask;
            m_wp = ((m_wp & ~cw) | sw) & req_mask;
            m_dp = (m_dp & ~cd) | sd;
            m_cprev = req_cold; m_wprev = req_warm; m_dprev = wdg_timeout_n;
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("m_busy", busy, int'(m_pos != 0));
        chk("m_cold", enable_cold_boot, int'(m_pos == 2 && m_cls != 1));
        chk("m_warm", enable_warm_boot, int'(m_pos == 2 && m_cls == 1));
        chk("m_gid", grant_id, m_gid);
`ifdef RST_SCHED_STATUS_EN
        chk("m_cnt", issue_cnt, m_cnt);
        chk("m_cause", last_cause, m_cause);
`else
        chk("m_cnt", issue_cnt, 0);
        chk("m_cause", last_cause, 0);
`endif
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    // lat counts negedges after the capture edge; -1 if no pulse in maxc.
    task automatic wait_pulse(input int maxc, output int lat, output int c, output int g);
        lat = -1; c = 0; g = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk); #1;
            if (enable_cold_boot || enable_warm_boot) begin
                lat = i; c = enable_cold_boot; g = grant_id;
                #1;
                break;
            end
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) step(1);
        chk("idle_wait", busy, 0);
    endtask

    task automatic idle_inputs();
        req_warm = '0; req_cold = '0; req_mask = '1; wdg_timeout_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] cold, warm, mask;
        bit           wdg;
        bit           exp_pulse, exp_cold;
        int           exp_gid;
    } vec_t;

    vec_t vt[5];
    int lat, c, g, npulse;

    initial begin
        vt[0] = '{4'b0000, 4'b0100, 4'b1111, 0, 1, 0, 2};
        vt[1] = '{4'b0010, 4'b0000, 4'b1111, 0, 1, 1, 1};
        vt[2] = '{4'b0001, 4'b0001, 4'b1111, 0, 1, 1, 0};
        vt[3] = '{4'b1000, 4'b0000, 4'b0111, 0, 0, 0, 0};
        vt[4] = '{4'b0000, 4'b0000, 4'b1111, 1, 1, 1, 7};

        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_en", {enable_cold_boot, enable_warm_boot}, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_cnt", issue_cnt, 0);
        chk("rst_cause", last_cause, 0);
        chk_on = 1'b1;
        rst_n = 1'b1;
        step(2);

        // directed table, each from idle; nothing may follow the first pulse
        foreach (vt[i]) begin
            wait_idle();
            req_mask = vt[i].mask; req_cold = vt[i].cold; req_warm = vt[i].warm;
            wdg_timeout_n = ~vt[i].wdg;
            wait_pulse(10, lat, c, g);
            if (vt[i].exp_pulse) begin
                chk($sformatf("t%0d_lat", i), lat, 2);
                chk($sformatf("t%0d_cold", i), c, int'(vt[i].exp_cold));
                chk($sformatf("t%0d_gid", i), g, vt[i].exp_gid);
            end else chk($sformatf("t%0d_nopulse", i), lat, -1);
            wait_pulse(70, lat, c, g);
            chk($sformatf("t%0d_nofollow", i), lat, -1);
            idle_inputs();
            step(2);
        end

        // class priority: cold 3 first, warm 0 one window later
        wait_idle();
        req_warm = 4'b0001; req_cold = 4'b1000;
        wait_pulse(10, lat, c, g);
        chk("prio_lat", lat, 2); chk("prio_cold", c, 1); chk("prio_gid", g, 3);
        wait_pulse(70, lat, c, g);
        chk("prio2_lat", lat, LOCK + 2); chk("prio2_cold", c, 0); chk("prio2_gid", g, 0);
        idle_inputs();

        // round robin over all four cold requesters
        wait_idle();
        req_cold = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(70, lat, c, g);
            chk($sformatf("rr%0d_lat", k), lat, (k == 0) ? 2 : LOCK + 2);
            chk($sformatf("rr%0d_gid", k), g, k);
        end
        idle_inputs();

        // watchdog beats a pending cold request
        wait_idle();
        req_cold = 4'b0010; wdg_timeout_n = 1'b0;
        wait_pulse(10, lat, c, g);
        chk("wdg_gid", g, 7); chk("wdg_cold", c, 1);
        step(1);
`ifdef RST_SCHED_STATUS_EN
        chk("wdg_cause", last_cause, 3);
`else
        chk("wdg_cause", last_cause, 0);
`endif
        wait_pulse(70, lat, c, g);
        chk("wdg_next_lat", lat, LOCK + 1); chk("wdg_next_gid", g, 1);
        idle_inputs();

        // mask drops warm_pend[1] captured during lockout
        wait_idle();
        req_cold = 4'b0001;
        wait_pulse(10, lat, c, g);
        step(3); req_warm = 4'b0010;
        step(5); req_mask = 4'b1101;
        step(1); req_mask = 4'b1111;
        wait_pulse(80, lat, c, g);
        chk("mask_nopulse", lat, -1);
        idle_inputs();

        // reset during lockout abandons everything
        wait_idle();
        req_warm = 4'b1000;
        wait_pulse(10, lat, c, g);
        step(5); req_warm = 4'b1100;
        step(2);
        rst_n = 1'b0; #1;
        chk("rl_en", {enable_cold_boot, enable_warm_boot}, 0);
        chk("rl_busy", busy, 0); chk("rl_gid", grant_id, 0);
        chk("rl_cnt", issue_cnt, 0); chk("rl_cause", last_cause, 0);
        idle_inputs();
        step(2); rst_n = 1'b1;
        wait_pulse(70, lat, c, g);
        chk("rl_nopulse", lat, -1);

        // saturation: 260 sequential warm requests
        npulse = 0;
        for (int k = 0; k < 260; k++) begin
            req_warm = 4'b0001;
            wait_pulse(10, lat, c, g);
            if (lat == 2) npulse++;
            req_warm = '0;
            step(LOCK + 2);
        end
        chk("sat_pulses", npulse, 260);
`ifdef RST_SCHED_STATUS_EN
        chk("sat_cnt", issue_cnt, 255);
`else
        chk("sat_cnt", issue_cnt, 0);
`endif

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            req_cold = req_cold ^ N'($urandom & $urandom & $urandom);
            req_warm = req_warm ^ N'($urandom & $urandom);
            req_mask = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
            if ($urandom_range(0, 59) == 0) wdg_timeout_n = ~wdg_timeout_n;
            step(1);
        end
        idle_inputs();
        step(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
